pcpu_platform_main: RTL and testbench

Board-level bring-up core of the pComputer FPGA. It runs a PSRAM power-up and ID self-test over single-bit SPI, and receives bytes from the CH375 USB bridge over a UART line. It also samples the SD-card DAT0 line and reports all status on the 4 LEDs. It sits directly on the board pins, below the CPU/bus fabric.

---
 rtl/pcpu_platform_pkg.sv | 25 ++
 rtl/pcpu_uart_rx.sv | 105 ++++++++++
 rtl/pcpu_platform_main.sv | 193 +++++++++++++++++++
 tb/tb_pcpu_platform_main.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpu_platform_pkg.sv
// pComputer board bring-up: shared constants, PSRAM command set
// and FSM state encoding.
package pcpu_platform_pkg;

    localparam int CLK_HZ_DEF = 100000000;
    localparam int BAUD_DEF   = 19200;
    localparam int BIT_DIV    = CLK_HZ_DEF / BAUD_DEF;

    localparam logic [7:0] CMD_RSTEN = 8'h66;
    localparam logic [7:0] CMD_RST   = 8'h99;
    localparam logic [7:0] CMD_RDID  = 8'h9F;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_RSTEN,
        ST_GAP1,
        ST_RST,
        ST_GAP2,
        ST_RDID,
        ST_CHECK,
        ST_PASS,
        ST_FAIL
    } psram_st_e;

endpackage

// File: rtl/pcpu_uart_rx.sv
// 8N1 UART receiver for the CH375 link; expects an already
// synchronized line and emits a one-cycle valid per good frame.
module pcpu_uart_rx
    import pcpu_platform_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEF,
    parameter int BAUD   = BAUD_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_WAIT  = 3'd4;

    logic [2:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          prev_q;

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = 1'b0;
        unique case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_i) st_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d = '0;
                    bit_d = '0;
                    st_d  = rx_i ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d = '0;
                    sh_d  = {rx_i, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) st_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d = '0;
                    if (rx_i) begin
                        data_d  = sh_q;
                        valid_d = 1'b1;
                        st_d    = RX_IDLE;
                    end else begin
                        st_d = RX_WAIT;
                    end
                end
            end
            RX_WAIT: begin
                // framing error: re-arm only once the line is idle again
                cnt_d = '0;
                if (rx_i) st_d = RX_IDLE;
            end
            default: st_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            prev_q  <= 1'b1;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            prev_q  <= rx_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pcpu_platform_main.sv
// Board bring-up core: PSRAM reset/ID self-test over SPI, CH375
// UART receive, SD DAT0 sampling and LED status.
module pcpu_platform_main
    import pcpu_platform_pkg::*;
#(
    parameter int         CLK_HZ       = CLK_HZ_DEF,
    parameter int         BAUD         = BAUD_DEF,
    parameter int         PWRUP_CYCLES = 15000,
    parameter int         CS_GAP       = 4,
    parameter logic [7:0] PSRAM_MFID   = 8'h0D,
    parameter logic [7:0] PSRAM_KGD    = 8'h5D
) (
    input  logic       sysclk,
    input  logic [1:0] sw,
    input  logic [1:0] btn,
    output logic [3:0] led,
    input  logic       sd_dat0,
    output logic       psram_ce,
    output logic       psram_sclk,
    output logic       psram_mosi,
    input  logic       psram_miso,
    output logic       psram_sio2,
    output logic       psram_sio3,
    input  logic       ch375_tx
);

    logic       rst;
    logic [4:0] s1_q, s2_q;
    logic       btn0_prev_q, btn0_rise;
    logic       miso_s, tx_s, sd_s;
    logic [1:0] btn_s;

    assign rst   = sw[0];
    assign btn_s = s2_q[4:3];
    assign sd_s  = s2_q[2];
    assign tx_s  = s2_q[1];
    assign miso_s = s2_q[0];
    assign btn0_rise = btn_s[0] & ~btn0_prev_q;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            s1_q        <= 5'b00010;
            s2_q        <= 5'b00010;
            btn0_prev_q <= 1'b0;
        end else begin
            s1_q        <= {btn, sd_dat0, ch375_tx, psram_miso};
            s2_q        <= s1_q;
            btn0_prev_q <= btn_s[0];
        end
    end

    psram_st_e   st_q, st_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  step_q, step_d;
    logic [5:0]  nb_q, nb_d;
    logic [47:0] sh_q, sh_d;
    logic [15:0] rx_q, rx_d;
    logic        ce_q, ce_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic [7:0]  cmd;

    assign cmd = (st_q == ST_RSTEN) ? CMD_RSTEN :
                 (st_q == ST_RST)   ? CMD_RST : CMD_RDID;

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        step_d = step_q;
        nb_d   = nb_q;
        sh_d   = sh_q;
        rx_d   = rx_q;
        ce_d   = ce_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        unique case (st_q)
            ST_PWRUP: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == 32'(PWRUP_CYCLES - 1)) begin
                    cnt_d = '0;
                    st_d  = ST_RSTEN;
                end
            end
            ST_GAP1, ST_GAP2: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == 32'(CS_GAP - 1)) begin
                    cnt_d = '0;
                    st_d  = (st_q == ST_GAP1) ? ST_RST : ST_RDID;
                end
            end
            ST_RSTEN, ST_RST, ST_RDID: begin
                // step: 0 ce low, 1 lead-in, 2 phase 0, 3 phase 1, 4 tail
                unique case (step_q)
                    3'd0: begin
                        ce_d   = 1'b0;
                        mosi_d = 1'b0;
                        sh_d   = {cmd, 40'h0};
                        nb_d   = (st_q == ST_RDID) ? 6'd48 : 6'd8;
                        step_d = 3'd1;
                    end
                    3'd1: begin
                        mosi_d = sh_q[47];
                        step_d = 3'd2;
                    end
                    3'd2: begin
                        sclk_d = 1'b1;
                        step_d = 3'd3;
                    end
                    3'd3: begin
                        sclk_d = 1'b0;
                        rx_d   = {rx_q[14:0], miso_s};
                        sh_d   = {sh_q[46:0], 1'b0};
                        mosi_d = (nb_q == 6'd1) ? 1'b0 : sh_q[46];
                        nb_d   = nb_q - 6'd1;
                        step_d = (nb_q == 6'd1) ? 3'd4 : 3'd2;
                    end
                    default: begin
                        ce_d   = 1'b1;
                        step_d = 3'd0;
                        unique case (1'b1)
                            st_q == ST_RSTEN: st_d = ST_GAP1;
                            st_q == ST_RST:   st_d = ST_GAP2;
                            default:          st_d = ST_CHECK;
                        endcase
                    end
                endcase
            end
            ST_CHECK: begin
                st_d = (rx_q == {PSRAM_MFID, PSRAM_KGD}) ? ST_PASS : ST_FAIL;
            end
            ST_PASS, ST_FAIL: begin
                if (btn0_rise) st_d = ST_RSTEN;
            end
            default: st_d = ST_PWRUP;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            st_q   <= ST_PWRUP;
            cnt_q  <= '0;
            step_q <= '0;
            nb_q   <= '0;
            sh_q   <= '0;
            rx_q   <= '0;
            ce_q   <= 1'b1;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            step_q <= step_d;
            nb_q   <= nb_d;
            sh_q   <= sh_d;
            rx_q   <= rx_d;
            ce_q   <= ce_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
        end
    end

    assign psram_ce   = ce_q;
    assign psram_sclk = sclk_q;
    assign psram_mosi = mosi_q;
    assign psram_sio2 = 1'b1;
    assign psram_sio3 = 1'b1;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_flag_q;

    pcpu_uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_uart_rx (
        .clk_i   (sysclk),
        .rst_i   (rst),
        .rx_i    (tx_s),
        .data_o  (rx_byte),
        .valid_o (rx_valid)
    );

    always_ff @(posedge sysclk) begin
        if (rst) rx_flag_q <= 1'b0;
        else if (rx_valid) rx_flag_q <= ~rx_flag_q;
    end

    always_comb begin
        if (sw[1]) led = btn_s[1] ? rx_byte[7:4] : rx_byte[3:0];
        else led = {rx_flag_q, sd_s, st_q == ST_FAIL, st_q == ST_PASS};
    end

endmodule

// File: tb/tb_pcpu_platform_main.sv
// Directed bench for pcpu_platform_main: PSRAM bring-up with an SPI
// slave model, UART frames, SD level and LED modes.
`timescale 1ns/1ps
module tb_pcpu_platform_main;

    // UART bit period shortened to 100 clocks to keep runs short
    localparam int BT = 1000;

    logic       sysclk = 1'b0;
    logic [1:0] sw = 2'b01;
    logic [1:0] btn = 2'b00;
    logic [3:0] led;
    logic       sd_dat0 = 1'b0;
    logic       psram_ce, psram_sclk, psram_mosi;
    logic       psram_miso = 1'b0;
    logic       psram_sio2, psram_sio3;
    logic       ch375_tx = 1'b1;

    int pass_cnt = 0;
    int chk_cnt = 0;
    logic [15:0] id_q = 16'h0D5D;

    always #5 sysclk = ~sysclk;

    pcpu_platform_main #(
        .CLK_HZ       (100000000),
        .BAUD         (1000000),
        .PWRUP_CYCLES (100),
        .CS_GAP       (4),
        .PSRAM_MFID   (8'h0D),
        .PSRAM_KGD    (8'h5D)
    ) dut (
        .sysclk     (sysclk),
        .sw         (sw),
        .btn        (btn),
        .led        (led),
        .sd_dat0    (sd_dat0),
        .psram_ce   (psram_ce),
        .psram_sclk (psram_sclk),
        .psram_mosi (psram_mosi),
        .psram_miso (psram_miso),
        .psram_sio2 (psram_sio2),
        .psram_sio3 (psram_sio3),
        .ch375_tx   (ch375_tx)
    );

    logic [47:0] fr_bits [16];
    int          fr_n [16];
    int          fr_gap [16];
    time         fr_t [16];
    int          nfr = 0;
    logic [47:0] cur = '0;
    int          nb = 0;
    int          gap = 0;
    int          st_gap = 0;
    time         st_t = 0;
    logic        prev_ce = 1'b1;
    logic        prev_sclk = 1'b0;

    always @(negedge sysclk) begin
        if (!psram_ce) begin
            if (prev_ce) begin
                cur = '0;
                nb = 0;
                st_gap = gap;
                st_t = $time;
            end
            if (psram_sclk && !prev_sclk) begin
                cur = {cur[46:0], psram_mosi};
                nb++;
            end
        end else begin
            if (!prev_ce) begin
                if (nfr < 16) begin
                    fr_bits[nfr] = cur;
                    fr_n[nfr] = nb;
                    fr_gap[nfr] = st_gap;
                    fr_t[nfr] = st_t;
                    nfr++;
                end
                gap = 0;
            end
            gap++;
        end
        prev_ce = psram_ce;
        prev_sclk = psram_sclk;
    end

    // SO runs one bit ahead to cover the two-flop miso synchronizer
    always @(negedge psram_sclk) begin
        if (!psram_ce && nb >= 31 && nb <= 46) begin
            #1 psram_miso = id_q[46 - nb];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        ch375_tx = 1'b0;
        #(BT);
        for (int i = 0; i < 8; i++) begin
            ch375_tx = d[i];
            #(BT);
        end
        ch375_tx = stop;
        #(BT);
        ch375_tx = 1'b1;
        #(2 * BT);
    endtask

    task automatic test_reset;
        sw = 2'b01;
        tick(400);
        chk_cnt++;
        if (led !== 4'h0) $display("FAIL rst_led got %h want 0", led);
        else pass_cnt++;
        chk_cnt++;
        if (psram_ce !== 1'b1) $display("FAIL rst_ce got %b want 1", psram_ce);
        else pass_cnt++;
        chk_cnt++;
        if (psram_sclk !== 1'b0) $display("FAIL rst_sclk got %b want 0", psram_sclk);
        else pass_cnt++;
        chk_cnt++;
        if (psram_mosi !== 1'b0) $display("FAIL rst_mosi got %b want 0", psram_mosi);
        else pass_cnt++;
        chk_cnt++;
        if ({psram_sio2, psram_sio3} !== 2'b11)
            $display("FAIL rst_sio got %b want 11", {psram_sio2, psram_sio3});
        else pass_cnt++;
    endtask

    task automatic test_bringup;
        int base;
        int k;
        base = nfr;
        id_q = 16'h0D5D;
        sw = 2'b00;
        k = 0;
        while (led[1:0] == 2'b00 && k < 2200) begin
            tick(1);
            k++;
        end
        chk_cnt++;
        if (led[1:0] !== 2'b01) $display("FAIL up_led got %b want 01", led[1:0]);
        else pass_cnt++;
        chk_cnt++;
        if (nfr - base !== 3) $display("FAIL up_nfr got %0d want 3", nfr - base);
        else pass_cnt++;
        chk_cnt++;
        if (fr_n[base] !== 8 || fr_bits[base][7:0] !== 8'h66)
            $display("FAIL up_rsten got %0d/%h want 8/66", fr_n[base], fr_bits[base][7:0]);
        else pass_cnt++;
        chk_cnt++;
        if (fr_n[base+1] !== 8 || fr_bits[base+1][7:0] !== 8'h99)
            $display("FAIL up_rst got %0d/%h want 8/99", fr_n[base+1], fr_bits[base+1][7:0]);
        else pass_cnt++;
        chk_cnt++;
        if (fr_n[base+2] !== 48 || fr_bits[base+2][47:16] !== 32'h9F000000)
            $display("FAIL up_rdid got %0d/%h want 48/9f000000",
                     fr_n[base+2], fr_bits[base+2][47:16]);
        else pass_cnt++;
        chk_cnt++;
        if (fr_gap[base+1] < 4 || fr_gap[base+2] < 4)
            $display("FAIL up_gap got %0d,%0d want >=4", fr_gap[base+1], fr_gap[base+2]);
        else pass_cnt++;
    endtask

    task automatic test_mismatch;
        int base;
        int k;
        time t0;
        base = nfr;
        id_q = 16'h0D00;
        t0 = $time;
        btn[0] = 1'b1;
        tick(4);
        btn[0] = 1'b0;
        tick(2);
        k = 0;
        while (led[1:0] == 2'b00 && k < 2000) begin
            tick(1);
            k++;
        end
        chk_cnt++;
        if (led[1:0] !== 2'b10) $display("FAIL mm_led got %b want 10", led[1:0]);
        else pass_cnt++;
        chk_cnt++;
        if (nfr - base !== 3) $display("FAIL mm_nfr got %0d want 3", nfr - base);
        else pass_cnt++;
        chk_cnt++;
        if (fr_bits[base][7:0] !== 8'h66)
            $display("FAIL mm_first got %h want 66", fr_bits[base][7:0]);
        else pass_cnt++;
        chk_cnt++;
        if (fr_t[base] - t0 >= 1000)
            $display("FAIL mm_nopwrup got %0t want <1000ns", fr_t[base] - t0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int base;
        int k;
        base = nfr;
        id_q = 16'h0D5D;
        btn[0] = 1'b1;
        tick(4);
        btn[0] = 1'b0;
        tick(56);
        btn[0] = 1'b1;
        tick(4);
        btn[0] = 1'b0;
        k = 0;
        while (led[1:0] == 2'b00 && k < 2000) begin
            tick(1);
            k++;
        end
        chk_cnt++;
        if (led[1:0] !== 2'b01) $display("FAIL b2b_led got %b want 01", led[1:0]);
        else pass_cnt++;
        chk_cnt++;
        if (nfr - base !== 3) $display("FAIL b2b_nfr got %0d want 3", nfr - base);
        else pass_cnt++;
    endtask

    task automatic test_uart;
        sw = 2'b00;
        send_byte(8'hD5, 1'b1);
        tick(2);
        chk_cnt++;
        if (led[3] !== 1'b1) $display("FAIL ua_flag got %b want 1", led[3]);
        else pass_cnt++;
        sw = 2'b10;
        tick(2);
        chk_cnt++;
        if (led !== 4'h5) $display("FAIL ua_lo got %h want 5", led);
        else pass_cnt++;
        btn[1] = 1'b1;
        tick(4);
        chk_cnt++;
        if (led !== 4'hD) $display("FAIL ua_hi got %h want d", led);
        else pass_cnt++;
        btn[1] = 1'b0;
        sw = 2'b00;
        tick(4);
    endtask

    task automatic test_framing;
        send_byte(8'h3C, 1'b0);
        tick(2);
        chk_cnt++;
        if (led[3] !== 1'b1) $display("FAIL fe_flag got %b want 1", led[3]);
        else pass_cnt++;
        sw = 2'b10;
        tick(2);
        chk_cnt++;
        if (led !== 4'h5) $display("FAIL fe_byte got %h want 5", led);
        else pass_cnt++;
        sw = 2'b00;
        send_byte(8'hA7, 1'b1);
        tick(2);
        chk_cnt++;
        if (led[3] !== 1'b0) $display("FAIL fe_next_flag got %b want 0", led[3]);
        else pass_cnt++;
        sw = 2'b10;
        tick(2);
        chk_cnt++;
        if (led !== 4'h7) $display("FAIL fe_next_lo got %h want 7", led);
        else pass_cnt++;
        btn[1] = 1'b1;
        tick(4);
        chk_cnt++;
        if (led !== 4'hA) $display("FAIL fe_next_hi got %h want a", led);
        else pass_cnt++;
        btn[1] = 1'b0;
        sw = 2'b00;
        tick(4);
    endtask

    task automatic test_sd;
        sw = 2'b00;
        sd_dat0 = 1'b0;
        tick(4);
        chk_cnt++;
        if (led[2] !== 1'b0) $display("FAIL sd_lo got %b want 0", led[2]);
        else pass_cnt++;
        sd_dat0 = 1'b1;
        tick(1);
        chk_cnt++;
        if (led[2] !== 1'b0) $display("FAIL sd_d1 got %b want 0", led[2]);
        else pass_cnt++;
        tick(1);
        chk_cnt++;
        if (led[2] !== 1'b1) $display("FAIL sd_d2 got %b want 1", led[2]);
        else pass_cnt++;
        sd_dat0 = 1'b0;
        tick(2);
        chk_cnt++;
        if (led[2] !== 1'b0) $display("FAIL sd_back got %b want 0", led[2]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_mismatch();
        test_back_to_back();
        test_uart();
        test_framing();
        test_sd();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
